// File: rtl/instr_decoder.sv
// Immediate-format decoder: combinational imm_src from op, plus a registered
// capture stage producing the sign-extended immediate and illegal-opcode flag.
module instr_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    output logic [2:0]  imm_src,
    input  logic        ir_write,
    input  logic [31:0] instr,
    output logic [31:0] imm_ext,
    output logic        illegal,
    output logic        valid
);

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100
    } imm_fmt_t;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_JALR   = 7'b1100111,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    function automatic imm_fmt_t decode_fmt(input logic [6:0] opc);
        imm_fmt_t fmt;
        fmt = FMT_I;
        case (opc)
            OPC_STORE:            fmt = FMT_S;
            OPC_BRANCH:           fmt = FMT_B;
            OPC_JAL:              fmt = FMT_J;
            OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
            default:              fmt = FMT_I;
        endcase
        return fmt;
    endfunction

    function automatic logic is_legal(input logic [6:0] opc);
        logic ok;
        ok = 1'b0;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE,
            OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: ok = 1'b1;
            default:                                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    imm_fmt_t    capture_fmt;
    logic [31:0] imm_next;

    always_comb begin
        imm_src = decode_fmt(op);
    end

    // Registered outputs are computed from the incoming word, so the captured
    // instruction itself never needs to be stored separately.
    always_comb begin
        capture_fmt = decode_fmt(instr[6:0]);
        imm_next    = '0;
        case (capture_fmt)
            FMT_S:   imm_next = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm_next = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   imm_next = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   imm_next = {instr[31:12], 12'b0};
            default: imm_next = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_ext <= '0;
            illegal <= 1'b0;
            valid   <= 1'b0;
        end else if (ir_write) begin
            imm_ext <= imm_next;
            illegal <= ~is_legal(instr[6:0]);
            valid   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed cases from the decode table
// plus randomized captures checked against an arithmetic reference model.
module tb_instr_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op = '0;
    logic [2:0]  imm_src;
    logic        ir_write = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] imm_ext;
    logic        illegal;
    logic        valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_imm   = '0;
    logic        exp_ill   = 1'b0;
    logic        exp_valid = 1'b0;

    logic [6:0] known_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                   7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111,
                                   7'b0010111, 7'b1110011};

    instr_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .imm_src  (imm_src),
        .ir_write (ir_write),
        .instr    (instr),
        .imm_ext  (imm_ext),
        .illegal  (illegal),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_fmt(input logic [6:0] o);
        if (o == 7'b0100011) return 3'd1;
        if (o == 7'b1100011) return 3'd2;
        if (o == 7'b1101111) return 3'd3;
        if (o == 7'b0110111 || o == 7'b0010111) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic model_illegal(input logic [6:0] o);
        foreach (known_ops[k]) if (known_ops[k] == o) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] i);
        logic [31:0] v;
        logic        s;
        s = i[31];
        case (model_fmt(i[6:0]))
            3'd1: begin
                v = ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
                if (s) v = v | 32'hFFFF_F000;
            end
            3'd2: begin
                v = (((i >> 8) & 32'hF) << 1) | (((i >> 25) & 32'h3F) << 5) | (((i >> 7) & 32'h1) << 11);
                if (s) v = v | 32'hFFFF_F000;
            end
            3'd3: begin
                v = (((i >> 21) & 32'h3FF) << 1) | (((i >> 20) & 32'h1) << 11) | (((i >> 12) & 32'hFF) << 12);
                if (s) v = v | 32'hFFF0_0000;
            end
            3'd4: v = i & 32'hFFFF_F000;
            default: begin
                v = i >> 20;
                if (s) v = v | 32'hFFFF_F000;
            end
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 3) != 0) w[6:0] = known_ops[$urandom_range(0, 9)];
        return w;
    endfunction

    task automatic capture(input logic [31:0] w);
        @(negedge clk);
        instr    = w;
        ir_write = 1'b1;
        @(posedge clk);
        exp_imm   = model_imm(w);
        exp_ill   = model_illegal(w[6:0]);
        exp_valid = 1'b1;
        #1;
        ir_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if ({imm_ext, illegal, valid} !== 34'd0) begin
            bad++;
            $display("FAIL reset_state: got imm=%h ill=%b valid=%b, want all zero", imm_ext, illegal, valid);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_imm = '0; exp_ill = 1'b0; exp_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({imm_ext, illegal, valid} !== 34'd0) begin
            bad++;
            $display("FAIL reset_release: got imm=%h ill=%b valid=%b, want all zero", imm_ext, illegal, valid);
        end
    endtask

    task automatic test_comb_decode();
        logic [6:0] ops  [10] = '{7'b0010011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111,
                                  7'b0000011, 7'b1100111, 7'b0010111, 7'b0110011, 7'b1111111};
        logic [2:0] want [10] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100,
                                  3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
        logic [6:0] r;
        for (int k = 0; k < 10; k++) begin
            op = ops[k];
            #1;
            total++;
            if (imm_src !== want[k]) begin
                bad++;
                $display("FAIL imm_src_table op=%b: got %b want %b", ops[k], imm_src, want[k]);
            end
        end
        for (int k = 0; k < 40; k++) begin
            r  = (k % 2 == 0) ? known_ops[$urandom_range(0, 9)] : 7'($urandom());
            op = r;
            #1;
            total++;
            if (imm_src !== model_fmt(r)) begin
                bad++;
                $display("FAIL imm_src_rand op=%b: got %b want %b", r, imm_src, model_fmt(r));
            end
        end
    endtask

    task automatic test_directed_capture();
        logic [31:0] words [5] = '{32'hFFF00093, 32'hFE000EE3, 32'h008000EF, 32'h123450B7, 32'h0000007F};
        logic [31:0] imms  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'h00000000};
        logic        ills  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            capture(words[k]);
            total++;
            if (imm_ext !== imms[k] || illegal !== ills[k] || valid !== 1'b1) begin
                bad++;
                $display("FAIL capture_%h: got imm=%h ill=%b valid=%b want imm=%h ill=%b valid=1",
                         words[k], imm_ext, illegal, valid, imms[k], ills[k]);
            end
        end
    endtask

    task automatic test_hold();
        capture(32'hFE000EE3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            instr    = rand_instr();
            ir_write = 1'b0;
            @(posedge clk); #1;
            total++;
            if (imm_ext !== 32'hFFFFFFFC || illegal !== 1'b0 || valid !== 1'b1) begin
                bad++;
                $display("FAIL hold: got imm=%h ill=%b valid=%b want imm=fffffffc ill=0 valid=1",
                         imm_ext, illegal, valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic        we;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            w  = rand_instr();
            we = ($urandom_range(0, 3) != 0);
            instr    = w;
            ir_write = we;
            @(posedge clk);
            if (we) begin
                exp_imm   = model_imm(w);
                exp_ill   = model_illegal(w[6:0]);
                exp_valid = 1'b1;
            end
            #1;
            total++;
            if (imm_ext !== exp_imm || illegal !== exp_ill || valid !== exp_valid) begin
                bad++;
                $display("FAIL random_capture instr=%h we=%b: got imm=%h ill=%b valid=%b want imm=%h ill=%b valid=%b",
                         w, we, imm_ext, illegal, valid, exp_imm, exp_ill, exp_valid);
            end
        end
        ir_write = 1'b0;
    endtask

    task automatic test_async_reset();
        capture(32'h123450B7);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({imm_ext, illegal, valid} !== 34'd0) begin
            bad++;
            $display("FAIL async_reset: got imm=%h ill=%b valid=%b, want all zero", imm_ext, illegal, valid);
        end
        op = 7'b1101111;
        #1;
        total++;
        if (imm_src !== 3'b011) begin
            bad++;
            $display("FAIL imm_src_in_reset: got %b want 011", imm_src);
        end
        // capture attempt while reset is held must be ignored
        @(negedge clk);
        instr    = 32'hFFF00093;
        ir_write = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({imm_ext, illegal, valid} !== 34'd0) begin
            bad++;
            $display("FAIL reset_dominates: got imm=%h ill=%b valid=%b, want all zero", imm_ext, illegal, valid);
        end
        @(negedge clk);
        ir_write = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({imm_ext, illegal, valid} !== 34'd0) begin
            bad++;
            $display("FAIL post_reset_idle: got imm=%h ill=%b valid=%b, want all zero", imm_ext, illegal, valid);
        end
        capture(32'hFFF00093);
        total++;
        if (imm_ext !== 32'hFFFFFFFF || illegal !== 1'b0 || valid !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_capture: got imm=%h ill=%b valid=%b want imm=ffffffff ill=0 valid=1",
                     imm_ext, illegal, valid);
        end
    endtask

    initial begin
        test_reset();
        test_comb_decode();
        test_directed_capture();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
